bp_me_wb_ram: RTL and testbench

// - Wishbone B4 classic (non-pipelined) slave with a byte-maskable SRAM. Sits directly downstream of
//   bp_me_wb_master and terminates its adr/dat/cyc/stb/sel/we bus.
// - Provides a synthesizable memory target for loopback benches and FPGA bring-up.
// - Adds programmable wait states and a bus error for out-of-range addresses.

---
 rtl/bp_me_wb_pkg.sv | 16 +
 rtl/bsg_mem_1rw_sync_mask_write_byte.sv | 36 +++
 rtl/bp_me_wb_ram.sv | 130 +++++++++++++
 tb/tb_bp_me_wb_ram.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_wb_pkg.sv
// Purpose: shared typedefs for the Wishbone adapter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_me_wb_pkg;

  // FSM states of the Wishbone SRAM slave.
  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_wait = 2'd1,
    e_resp = 2'd2
  } bp_me_wb_ram_state_e;

  // Wait-state counter width; covers wait_cycles_p in 0..15.
  localparam int wb_wait_cnt_width_lp = 4;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Purpose: single-port synchronous SRAM with per-byte write enables.
// Latency: read data valid one cycle after a read with v_i=1; writes land on the same edge.
// Backpressure: none, accepts one access per cycle whenever v_i is high.
// Ports: clk_i; v_i access valid; w_i 1=write; addr_i word address;
//        data_i write data; write_mask_i byte enables; data_o registered read data.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int data_width_p = 64,
  parameter int els_p        = 1024,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]  data_o
);

  logic [data_width_p-1:0] mem [els_p];

  // No reset: contents survive reset and the array can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        for (int i = 0; i < mask_width_lp; i++) begin
          if (write_mask_i[i]) mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
        end
      end else begin
        data_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/bp_me_wb_ram.sv
// Purpose: Wishbone B4 classic slave terminating the bus into a byte-maskable SRAM.
// Latency: request accepted at edge N, ack/err in cycle N+1+wait_cycles_p.
// Backpressure: one request in flight; a new request is only accepted from e_idle.
// Ports: clk_i/reset_i (async, active-high); adr_i/dat_i/sel_i/we_i request fields;
//        cyc_i/stb_i request qualifiers; dat_o read data; ack_o normal end; err_o address error.
module bp_me_wb_ram
  import bp_me_wb_pkg::*;
#(
  parameter int data_width_p  = 64,
  parameter int adr_width_p   = 29,
  parameter int els_p         = 1024,
  parameter int wait_cycles_p = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [adr_width_p-1:0]    adr_i,
  input  logic [data_width_p-1:0]   dat_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic [data_width_p/8-1:0] sel_i,
  input  logic                      we_i,
  output logic [data_width_p-1:0]   dat_o,
  output logic                      ack_o,
  output logic                      err_o
);

  localparam int sram_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int mask_width_lp      = data_width_p / 8;
  localparam logic [adr_width_p:0] els_lp = (adr_width_p + 1)'(els_p);
  localparam logic [wb_wait_cnt_width_lp-1:0] wait_load_lp =
    (wait_cycles_p == 0) ? '0 : wb_wait_cnt_width_lp'(wait_cycles_p - 1);

  bp_me_wb_ram_state_e state_r, state_n;

  logic [wb_wait_cnt_width_lp-1:0] cnt_r;
  logic [sram_addr_width_lp-1:0]   adr_r;
  logic [data_width_p-1:0]         dat_r;
  logic [mask_width_lp-1:0]        sel_r;
  logic                            we_r;
  logic                            oob_r;

  logic                          req;
  logic                          is_idle;
  logic                          oob_now;
  logic [sram_addr_width_lp-1:0] req_adr;
  logic [data_width_p-1:0]       req_dat;
  logic [mask_width_lp-1:0]      req_sel;
  logic                          req_we;
  logic                          req_oob;
  logic                          sram_v;
  logic [data_width_p-1:0]       sram_data;

  assign req     = cyc_i & stb_i;
  assign is_idle = (state_r == e_idle);
  assign oob_now = ({1'b0, adr_i} >= els_lp);

  // With zero wait states the SRAM is accessed on the accept edge itself,
  // so the live bus feeds it in e_idle; otherwise the latched copy does.
  assign req_adr = is_idle ? adr_i[sram_addr_width_lp-1:0] : adr_r;
  assign req_dat = is_idle ? dat_i   : dat_r;
  assign req_sel = is_idle ? sel_i   : sel_r;
  assign req_we  = is_idle ? we_i    : we_r;
  assign req_oob = is_idle ? oob_now : oob_r;

  // e_resp is only ever entered from e_idle or e_wait, so this fires
  // exactly on the edge that enters it.
  assign sram_v = (state_n == e_resp) & ~req_oob;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: if (req) state_n = (wait_cycles_p == 0) ? e_resp : e_wait;
      e_wait: begin
        if (!cyc_i)          state_n = e_idle;  // master aborted
        else if (cnt_r == 0) state_n = e_resp;
      end
      e_resp:  state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Request latch and wait counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
      adr_r <= '0;
      dat_r <= '0;
      sel_r <= '0;
      we_r  <= 1'b0;
      oob_r <= 1'b0;
    end else if (is_idle && req) begin
      cnt_r <= wait_load_lp;
      adr_r <= adr_i[sram_addr_width_lp-1:0];
      dat_r <= dat_i;
      sel_r <= sel_i;
      we_r  <= we_i;
      oob_r <= oob_now;
    end else if (state_r == e_wait && cnt_r != 0) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  // Outputs decode from state only, so reset clears them without a clock.
  always_comb begin
    ack_o = (state_r == e_resp) & ~oob_r;
    err_o = (state_r == e_resp) &  oob_r;
    dat_o = ((state_r == e_resp) && !oob_r && !we_r) ? sram_data : '0;
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .data_width_p(data_width_p),
    .els_p       (els_p)
  ) u_sram (
    .clk_i       (clk_i),
    .v_i         (sram_v),
    .w_i         (req_we),
    .addr_i      (req_adr),
    .data_i      (req_dat),
    .write_mask_i(req_sel),
    .data_o      (sram_data)
  );

endmodule

// File: tb/tb_bp_me_wb_ram.sv
// Purpose: self-checking bench for bp_me_wb_ram, zero-wait and three-wait instances.
// Latency: expects ack/err in cycle N+1 (dut0) and N+4 (dut1) after accept edge N.
// Backpressure: master holds cyc/stb until termination, then drops them.
module tb_bp_me_wb_ram;

  localparam int ELS = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [28:0] adr  [2];
  logic [63:0] dat  [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic [7:0]  sel  [2];
  logic        we   [2];
  logic [63:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];

  bp_me_wb_ram #(.data_width_p(64), .adr_width_p(29), .els_p(ELS), .wait_cycles_p(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .adr_i(adr[0]), .dat_i(dat[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
    .sel_i(sel[0]), .we_i(we[0]), .dat_o(rdat[0]), .ack_o(ack[0]), .err_o(err[0]));

  bp_me_wb_ram #(.data_width_p(64), .adr_width_p(29), .els_p(ELS), .wait_cycles_p(3)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .adr_i(adr[1]), .dat_i(dat[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
    .sel_i(sel[1]), .we_i(we[1]), .dat_o(rdat[1]), .ack_o(ack[1]), .err_o(err[1]));

  int tests = 0;
  int fails = 0;

  // Reference memory: what each instance's SRAM must hold.
  logic [63:0] mdl [2][ELS];

  typedef struct {
    bit          w;
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    bit          e_ack;
    bit          e_err;
    logic [63:0] e_dat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = s[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  function automatic int lat_exp(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // One Wishbone classic transaction. Request fields are scrambled right
  // after acceptance to prove the slave works from its latched copy.
  task automatic access(input int d, input bit w, input logic [28:0] a, input logic [63:0] wd,
                        input logic [7:0] s, output logic [63:0] rd, output bit got_ack,
                        output bit got_err, output int lat);
    adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk); #1;
    adr[d] = 29'($urandom); dat[d] = {$urandom, $urandom}; sel[d] = 8'($urandom); we[d] = 1'($urandom);
    got_ack = 1'b0; got_err = 1'b0; lat = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        got_ack = ack[d]; got_err = err[d]; rd = rdat[d]; lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    check($sformatf("dut%0d_pulse_end", d), {62'd0, ack[d], err[d]}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Access checked against the reference memory; a latency of 0 means timeout.
  task automatic do_and_check(input int d, input bit w, input logic [28:0] a,
                              input logic [63:0] wd, input logic [7:0] s, input string name);
    bit          oob;
    logic [63:0] exp_d, rd;
    bit          ga, ge;
    int          lat;
    oob   = ({3'b0, a} >= 32'(ELS));
    exp_d = (!w && !oob) ? mdl[d][a[9:0]] : 64'd0;
    access(d, w, a, wd, s, rd, ga, ge, lat);
    if (w && !oob) mdl[d][a[9:0]] = merge(mdl[d][a[9:0]], wd, s);
    check($sformatf("%s_d%0d_ack", name, d), 64'(ga), 64'(!oob));
    check($sformatf("%s_d%0d_err", name, d), 64'(ge), 64'(oob));
    check($sformatf("%s_d%0d_dat", name, d), rd, exp_d);
    check($sformatf("%s_d%0d_lat", name, d), 64'(lat), 64'(lat_exp(d)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    bit          ga, ge, seen;
    int          lat;

    vecs[0]  = '{1'b1, 29'd0,          64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0, 64'd0};
    vecs[1]  = '{1'b1, 29'd5,          64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1, 1'b0, 64'd0};
    vecs[2]  = '{1'b0, 29'd5,          64'd0,                   8'hFF, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3]  = '{1'b1, 29'd5,          64'h1111_1111_1111_1111, 8'h0F, 1'b1, 1'b0, 64'd0};
    vecs[4]  = '{1'b0, 29'd5,          64'd0,                   8'hFF, 1'b1, 1'b0, 64'hDEAD_BEEF_1111_1111};
    vecs[5]  = '{1'b1, 29'd5,          64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 1'b1, 1'b0, 64'd0};
    vecs[6]  = '{1'b0, 29'd5,          64'd0,                   8'hFF, 1'b1, 1'b0, 64'hDEAD_BEEF_1111_1111};
    vecs[7]  = '{1'b1, 29'd1024,       64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b1, 64'd0};
    vecs[8]  = '{1'b0, 29'd1024,       64'd0,                   8'hFF, 1'b0, 1'b1, 64'd0};
    vecs[9]  = '{1'b0, 29'd0,          64'd0,                   8'hFF, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[10] = '{1'b1, 29'd1023,       64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 1'b0, 64'd0};
    vecs[11] = '{1'b0, 29'd1023,       64'd0,                   8'hFF, 1'b1, 1'b0, 64'hFEDC_BA98_7654_3210};
    vecs[12] = '{1'b1, 29'h1FFF_FFFF,  64'h5555_5555_5555_5555, 8'hFF, 1'b0, 1'b1, 64'd0};
    vecs[13] = '{1'b1, 29'd7,          64'h7777_0000_7777_0000, 8'hFF, 1'b1, 1'b0, 64'd0};
    vecs[14] = '{1'b1, 29'd5,          64'h2222_2222_2222_2222, 8'h81, 1'b1, 1'b0, 64'd0};
    vecs[15] = '{1'b0, 29'd5,          64'd0,                   8'hFF, 1'b1, 1'b0, 64'h22AD_BEEF_1111_1122};

    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat[d] = '0; cyc[d] = 1'b0; stb[d] = 1'b0; sel[d] = '0; we[d] = 1'b0;
    end

    // Reset state
    rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_d%0d_ack", d), 64'(ack[d]), 64'd0);
      check($sformatf("reset_d%0d_err", d), 64'(err[d]), 64'd0);
      check($sformatf("reset_d%0d_dat", d), rdat[d], 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        access(d, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, ga, ge, lat);
        check($sformatf("vec%0d_d%0d_ack", i, d), 64'(ga), 64'(vecs[i].e_ack));
        check($sformatf("vec%0d_d%0d_err", i, d), 64'(ge), 64'(vecs[i].e_err));
        check($sformatf("vec%0d_d%0d_dat", i, d), rd, vecs[i].e_dat);
        check($sformatf("vec%0d_d%0d_lat", i, d), 64'(lat), 64'(lat_exp(d)));
        if (vecs[i].w && vecs[i].e_ack)
          mdl[d][vecs[i].a[9:0]] = merge(mdl[d][vecs[i].a[9:0]], vecs[i].d, vecs[i].s);
      end
    end

    // Abort: drop cyc one cycle after accept while dut1 is stalling
    adr[1] = 29'd7; dat[1] = 64'hBAD0_BAD0_BAD0_BAD0; sel[1] = 8'hFF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= ack[1] | err[1];
    end
    check("abort_no_term", 64'(seen), 64'd0);
    @(posedge clk); #1;
    do_and_check(1, 1'b0, 29'd7, 64'd0, 8'hFF, "abort_readback");

    // stb without cyc is not a request
    adr[0] = 29'd7; dat[0] = 64'hBAD1_BAD1_BAD1_BAD1; sel[0] = 8'hFF; we[0] = 1'b1; stb[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen |= ack[0] | err[0];
    end
    check("stb_only_no_term", 64'(seen), 64'd0);
    @(posedge clk); #1;
    stb[0] = 1'b0;
    @(posedge clk); #1;
    do_and_check(0, 1'b0, 29'd7, 64'd0, 8'hFF, "stb_only_readback");

    // Async reset in the middle of dut1's wait states
    adr[1] = 29'd5; sel[1] = 8'hFF; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_wait_ack", 64'(ack[1]), 64'd0);
    check("rst_wait_err", 64'(err[1]), 64'd0);
    check("rst_wait_dat", rdat[1], 64'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= ack[1] | err[1];
    end
    check("rst_wait_no_term", 64'(seen), 64'd0);
    @(posedge clk); #1;
    do_and_check(1, 1'b0, 29'd5, 64'd0, 8'hFF, "rst_wait_after");

    // Async reset while dut0 is driving a read response
    adr[0] = 29'd5; sel[0] = 8'hFF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #3;
    check("rst_resp_pre_ack", 64'(ack[0]), 64'd1);
    check("rst_resp_pre_dat", rdat[0], mdl[0][5]);
    rst = 1'b1;
    #1;
    check("rst_resp_ack", 64'(ack[0]), 64'd0);
    check("rst_resp_dat", rdat[0], 64'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_and_check(0, 1'b0, 29'd5, 64'd0, 8'hFF, "rst_resp_after");

    // Randomized traffic against the reference memory
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++)
        do_and_check(d, 1'b1, 29'(a), {$urandom, $urandom}, 8'hFF, "preload");
      for (int n = 0; n < 150; n++) begin
        logic [28:0] ra;
        if ($urandom_range(0, 7) == 0) ra = 29'(ELS + $urandom_range(0, 100000));
        else                           ra = 29'($urandom_range(0, 15));
        do_and_check(d, 1'($urandom), ra, {$urandom, $urandom}, 8'($urandom), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
